// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round-sequencing FSM for the memory-pattern game
module game_flow_ctrl #(
    parameter int SHOW_TICKS    = 8,
    parameter int GAP_TICKS     = 4,
    parameter int INPUT_TIMEOUT = 64,
    parameter int FAIL_HOLD     = 4,
    parameter int MAX_ROUND     = 5,
    parameter int MAX_LEN       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_code,
    input  logic [3:0] difficulty_k,
    input  logic [2:0] current_round,
    output logic [3:0] led_onehot,
    output logic       round_clear,
    output logic       game_fail,
    output logic       game_reset,
    output logic       game_over,
    output logic [2:0] fsm_state
);
    localparam int T_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int T_B = (INPUT_TIMEOUT > FAIL_HOLD) ? INPUT_TIMEOUT : FAIL_HOLD;
    localparam int TW  = $clog2(((T_A > T_B) ? T_A : T_B) + 1);
    localparam int IW  = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_CLEAR    = 3'd5,
        S_FAIL     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   len_q, len_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            last_round_q, last_round_d;
    logic [1:0]      pat_q [MAX_LEN];
    logic            pat_we;
    logic [1:0]      pat_wdata;
    logic [IW-1:0]   len_k;
    logic [IW-1:0]   len_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            timer_q      <= '0;
            lfsr_q       <= 16'hACE1;
            last_round_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            timer_q      <= timer_d;
            lfsr_q       <= lfsr_d;
            last_round_q <= last_round_d;
        end
    end

    // Pattern storage needs no reset; every entry is rewritten in GEN before it is read.
    always_ff @(posedge clk) begin
        if (pat_we) begin
            pat_q[idx_q] <= pat_wdata;
        end
    end

    always_comb begin
        if (difficulty_k == 4'd0) begin
            len_k = IW'(1);
        end else if (32'(difficulty_k) > MAX_LEN) begin
            len_k = IW'(MAX_LEN);
        end else begin
            len_k = IW'(difficulty_k);
        end
        // idx is zero only on the first GEN cycle, where len_q is not yet valid.
        len_cur = (idx_q == '0) ? len_k : len_q;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        timer_d      = timer_q;
        last_round_d = last_round_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        pat_we       = 1'b0;
        pat_wdata    = lfsr_q[1:0];
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_GEN;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            S_GEN: begin
                pat_we = 1'b1;
                if (idx_q == '0) begin
                    len_d = len_k;
                end
                if (idx_q == len_cur - 1'b1) begin
                    state_d = S_SHOW_ON;
                    idx_d   = '0;
                    timer_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SHOW_ON: begin
                if (timer_q == TW'(SHOW_TICKS - 1)) begin
                    state_d = S_SHOW_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SHOW_OFF: begin
                if (timer_q == TW'(GAP_TICKS - 1)) begin
                    timer_d = '0;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = S_WAIT_IN;
                        idx_d   = '0;
                    end else begin
                        state_d = S_SHOW_ON;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_IN: begin
                if (btn_valid) begin
                    timer_d = '0;
                    if (btn_code == pat_q[idx_q]) begin
                        if (idx_q == len_q - 1'b1) begin
                            state_d      = S_CLEAR;
                            idx_d        = '0;
                            last_round_d = (32'(current_round) >= MAX_ROUND);
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d      = S_FAIL;
                        idx_d        = '0;
                        last_round_d = (32'(current_round) >= MAX_ROUND);
                    end
                end else if (timer_q == TW'(INPUT_TIMEOUT - 1)) begin
                    state_d      = S_FAIL;
                    idx_d        = '0;
                    timer_d      = '0;
                    last_round_d = (32'(current_round) >= MAX_ROUND);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = last_round_q ? S_DONE : S_GEN;
                idx_d   = '0;
                timer_d = '0;
            end
            S_FAIL: begin
                if (timer_q == TW'(FAIL_HOLD - 1)) begin
                    state_d = last_round_q ? S_DONE : S_GEN;
                    idx_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        led_onehot  = 4'h0;
        round_clear = 1'b0;
        game_fail   = 1'b0;
        game_over   = 1'b0;
        game_reset  = 1'b0;
        fsm_state   = state_q;
        case (state_q)
            S_IDLE:    game_reset  = start & rst_n;
            S_SHOW_ON: led_onehot  = 4'b0001 << pat_q[idx_q];
            S_CLEAR:   round_clear = 1'b1;
            S_FAIL:    game_fail   = 1'b1;
            S_DONE: begin
                game_over  = 1'b1;
                led_onehot = 4'hF;
                game_reset = start & rst_n;
            end
            default: begin
                led_onehot = 4'h0;
            end
        endcase
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl
module tb_game_flow_ctrl;
    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_code = 2'd0;
    logic [3:0] difficulty_k = 4'd4;
    logic [2:0] current_round = 3'd1;
    logic [3:0] led_onehot;
    logic       round_clear, game_fail, game_reset, game_over;
    logic [2:0] fsm_state;

    game_flow_ctrl #(
        .SHOW_TICKS(2), .GAP_TICKS(1), .INPUT_TIMEOUT(16), .FAIL_HOLD(3),
        .MAX_ROUND(5), .MAX_LEN(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn_valid(btn_valid),
        .btn_code(btn_code), .difficulty_k(difficulty_k), .current_round(current_round),
        .led_onehot(led_onehot), .round_clear(round_clear), .game_fail(game_fail),
        .game_reset(game_reset), .game_over(game_over), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int cyc; } ev_t;     // kind: 0 reset, 1 clear, 2 fail
    typedef struct { logic [3:0] val; int cyc; } led_t;

    ev_t        ev_q[$];
    led_t       led_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [1:0] pat [LEN];
    logic       fail_prev = 1'b0;
    int         fail_run = 0;

    function automatic logic [15:0] adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= adv(m_lfsr, 1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = ev_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        led_t l;
        if (!rst_n) begin
            fail_prev = 1'b0;
            fail_run  = 0;
        end else begin
            if (game_reset) check_ev(0);
            if (round_clear) check_ev(1);
            if (game_fail && !fail_prev) check_ev(2);
            if (game_fail) fail_run++;
            else if (fail_run > 0) begin
                chk("fail_width", fail_run, 3);
                fail_run = 0;
            end
            fail_prev = game_fail;
            chk("ctrl_exclusive", int'(round_clear) + int'(game_fail) + int'(game_reset) <= 1, 1);
            if (!game_over) begin
                chk("led_onehot_or_zero", $countones(led_onehot) <= 1, 1);
                if (led_onehot != 4'h0) begin
                    if (led_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_led: %h at cycle %0d", led_onehot, cyc);
                    end else begin
                        l = led_q.pop_front();
                        chk("led_value", int'(led_onehot), int'(l.val));
                        chk("led_cycle", cyc, l.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        if (t < cyc) chk("schedule", cyc, t);
        while (cyc < t) tick();
    endtask

    task automatic plan();
        logic [15:0] v;
        int g;
        g = cyc;
        for (int i = 0; i < LEN; i++) begin
            v = adv(m_lfsr, i);
            pat[i] = v[1:0];
            for (int j = 0; j < 2; j++)
                led_q.push_back('{val: 4'b0001 << v[1:0], cyc: g + LEN + 3 * i + j});
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        ev_q.push_back('{kind: 0, cyc: cyc});
        tick();
        start = 1'b0;
        chk("state_gen_after_start", int'(fsm_state), 1);
    endtask

    // mode 0: all correct, 1: wrong at pos, 2: timeout after pos correct, 3: first press at last timer tick
    task automatic play(input int mode, input int pos, input int gap, input bit last);
        int w, prev, p, d, nxt;
        bit ended;
        plan();
        w = cyc + 4 * LEN;
        prev = w;
        ended = 1'b0;
        nxt = 0;
        for (int i = 0; i < LEN; i++) begin
            if (ended || (mode == 2 && i == pos)) break;
            if (gap > 0) d = (i == 0) ? 0 : gap - 1;
            else if (mode == 3 && i == 0) d = 15;
            else d = $urandom_range(0, 7);
            p = prev + d;
            wait_until(p);
            if (i == 0) chk("state_wait_in", int'(fsm_state), 4);
            btn_valid = 1'b1;
            if (mode == 1 && i == pos) begin
                btn_code = pat[i] ^ 2'($urandom_range(1, 3));
                ev_q.push_back('{kind: 2, cyc: p + 1});
                nxt = p + 4;
                ended = 1'b1;
            end else begin
                btn_code = pat[i];
                if (i == LEN - 1) begin
                    ev_q.push_back('{kind: 1, cyc: p + 1});
                    nxt = p + 2;
                    ended = 1'b1;
                end
            end
            tick();
            btn_valid = 1'b0;
            prev = p + 1;
        end
        if (!ended) begin
            ev_q.push_back('{kind: 2, cyc: prev + 16});
            nxt = prev + 19;
        end
        wait_until(nxt);
        chk("state_after_round", int'(fsm_state), last ? 7 : 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick(); tick();
        chk("reset_state", int'(fsm_state), 0);
        chk("reset_outputs", int'({led_onehot, round_clear, game_fail, game_reset, game_over}), 0);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 5)) tick();

        do_start();
        play(0, 0, 5, 1'b0);
        play(1, 1, 0, 1'b0);
        play(2, 0, 0, 1'b0);
        play(3, 0, 0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            current_round = 3'($urandom_range(0, 4));
            play($urandom_range(0, 2), $urandom_range(0, LEN - 1), 0, 1'b0);
        end

        current_round = 3'd5;
        play(0, 0, 0, 1'b1);
        chk("done_game_over", int'(game_over), 1);
        chk("done_leds", int'(led_onehot), 15);
        btn_valid = 1'b1;
        btn_code  = 2'($urandom_range(0, 3));
        tick();
        btn_valid = 1'b0;
        tick();
        chk("done_ignores_btn", int'(fsm_state), 7);
        current_round = 3'd1;
        do_start();
        play(1, 0, 0, 1'b0);

        plan();
        wait_until(cyc + LEN + 1);
        chk("state_show_on", int'(fsm_state), 2);
        rst_n = 1'b0;
        led_q.delete();
        ev_q.delete();
        #1;
        chk("midreset_state", int'(fsm_state), 0);
        chk("midreset_outputs", int'({led_onehot, round_clear, game_fail, game_reset, game_over}), 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        do_start();
        play(0, 0, 0, 1'b0);
        play(2, 2, 0, 1'b0);

        tick();
        chk("pending_events", ev_q.size(), 0);
        chk("pending_leds", led_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Round-sequencing FSM for the memory-pattern game.
- Generates a pseudo-random button pattern of length difficulty_k and plays it on the LEDs.
- Checks the player's button entries, then drives the game-state register's round_clear / game_fail / game_reset controls.
- Sits between the button debouncer/encoder, the LED driver and the game-state register.

Parameters:
- SHOW_TICKS, 8, cycles each pattern step is lit
- GAP_TICKS, 4, dark cycles between steps
- INPUT_TIMEOUT, 64, idle cycles allowed between player entries before failure
- FAIL_HOLD, 4, cycles game_fail is held high
- MAX_ROUND, 5, last playable round
- MAX_LEN, 12, pattern buffer depth (entries of 2 bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start/restart request
- btn_valid  in  1  one-cycle strobe: player pressed a button
- btn_code  in  2  button index, valid with btn_valid
- difficulty_k  in  4  pattern length from the game-state register
- current_round  in  3  round number from the game-state register
- led_onehot  out  4  pattern display, one-hot or zero
- round_clear  out  1  one-cycle pulse: pattern entered correctly
- game_fail  out  1  held high FAIL_HOLD cycles on wrong entry or timeout
- game_reset  out  1  one-cycle pulse restarting the game-state register
- game_over  out  1  high in DONE
- fsm_state  out  3  encoded state for debug: IDLE=0 GEN=1 SHOW_ON=2 SHOW_OFF=3 WAIT_IN=4 CLEAR=5 FAIL=6 DONE=7

Behaviour:
- Reset: fsm_state=IDLE; all outputs 0; idx=0; timers=0; LFSR=16'hACE1; buffer contents don't-care.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle in every state, including IDLE.
- IDLE / DONE, start=1: game_reset=1 for that cycle only; next state GEN. start is ignored in all other states.
- GEN:
  - First cycle latches len = min(difficulty_k, MAX_LEN); difficulty_k=0 is treated as 1.
  - Writes buf[i] = lfsr[1:0] for i=0..len-1, one per cycle, starting that first cycle. Takes len cycles.
  - Then enters SHOW_ON with idx=0.
- SHOW_ON: led_onehot = 1<<buf[idx] for exactly SHOW_TICKS cycles, then SHOW_OFF.
- SHOW_OFF:
  - led_onehot=0 for exactly GAP_TICKS cycles, then idx increments.
  - If idx was len-1: go to WAIT_IN with idx=0 and timer=0. Otherwise return to SHOW_ON.
- WAIT_IN:
  - led_onehot=0; timer increments each cycle without btn_valid.
  - btn_valid with btn_code==buf[idx]: timer=0, idx increments. If it was the last entry, go to CLEAR.
  - btn_valid with btn_code!=buf[idx]: go to FAIL.
  - timer reaches INPUT_TIMEOUT-1 with no btn_valid: go to FAIL. If btn_valid arrives in the same cycle, btn_valid wins.
  - On leaving WAIT_IN, latch last_round = (current_round >= MAX_ROUND).
- CLEAR: single cycle, round_clear=1. Next state DONE if last_round, else GEN.
- FAIL:
  - game_fail=1 for exactly FAIL_HOLD cycles; the game-state register edge-detects it, so it is counted once.
  - Next state DONE if last_round, else GEN.
  - GEN lasts ≥1 cycle with game_fail=0, so back-to-back failures each produce a fresh rising edge.
- DONE: game_over=1; led_onehot=4'hF; waits for start.
- btn_valid outside WAIT_IN is ignored. The buffer is not cleared between rounds.
- round_clear, game_fail and game_reset are never high in the same cycle.
- rst_n assertion mid-round returns to IDLE immediately, with all outputs 0.

Test Plan (SHOW_TICKS=2, GAP_TICKS=1, INPUT_TIMEOUT=16, FAIL_HOLD=3, difficulty_k held at 4):
- Reset then start pulse -> game_reset high exactly 1 cycle; GEN for 4 cycles; 4×(2 lit + 1 dark) LED cycles, each lit value one-hot; then WAIT_IN.
- Bench enters buf[0..3] correctly, spaced 5 cycles apart -> round_clear single pulse one cycle after the 4th btn_valid; fsm_state returns to GEN; game_fail stays 0.
- Second entry wrong -> game_fail high exactly 3 cycles; round_clear stays 0; then GEN.
- No input after the show -> game_fail rises after exactly 16 WAIT_IN cycles. Second variant: btn_valid (correct) on cycle 16 -> no fail, timer reset.
- current_round=5 and the pattern is cleared -> round_clear pulse, then DONE with game_over=1, LEDs=F. A btn_valid in DONE -> ignored. Start -> game_reset pulse, then GEN.
- rst_n pulsed low during SHOW_ON -> outputs 0, fsm_state=IDLE within the same cycle; LFSR=16'hACE1 after release.
